// File: rtl/stoch_decode_pkg.sv
// Shared types and helpers for the signed stochastic feature-map decoder.
package stoch_decode_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Signed count must span [-N, +N] with N = 2^window_log2.
    function automatic int cnt_width(input int window_log2);
        return window_log2 + 2;
    endfunction

endpackage

// File: rtl/stoch_signed_counter.sv
// Per-element bipolar integrator: +1 on p-only, -1 on m-only, hold otherwise.
module stoch_signed_counter #(
    parameter int CNT_W = 10
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    p,
    input  logic                    m,
    output logic signed [CNT_W-1:0] cnt
);

    logic signed [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST)
            r_cnt <= '0;
        else if (clr)
            r_cnt <= '0;
        else if (en && (p != m))
            r_cnt <= p ? r_cnt + CNT_W'(1) : r_cnt - CNT_W'(1);
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/stoch_signed_fmap_decoder.sv
// Integrates every element's (x_p, x_m) stream pair over 2^WINDOW_LOG2 cycles
// and then drains the signed counts one element per valid/ready beat.
module stoch_signed_fmap_decoder
    import stoch_decode_pkg::*;
#(
    parameter int HEIGHT      = 4,
    parameter int WIDTH       = 4,
    parameter int CHANNELS    = 3,
    parameter int WINDOW_LOG2 = 8,
    localparam int CNT_W      = cnt_width(WINDOW_LOG2),
    localparam int NUM_EL     = HEIGHT * WIDTH * CHANNELS,
    localparam int IDX_W      = (NUM_EL > 1) ? $clog2(NUM_EL) : 1
) (
    input  logic                                         CLK,
    input  logic                                         nRST,
    input  logic                                         start,
    input  logic [HEIGHT-1:0][WIDTH-1:0][CHANNELS-1:0]   x_p,
    input  logic [HEIGHT-1:0][WIDTH-1:0][CHANNELS-1:0]   x_m,
    output logic                                         busy,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic signed [CNT_W-1:0]                      out_data,
    output logic [IDX_W-1:0]                             out_idx,
    output logic                                         out_last
);

    localparam logic [WINDOW_LOG2-1:0] WIN_LAST = '1;
    localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(NUM_EL - 1);

    state_t                          r_state, w_next;
    logic [WINDOW_LOG2-1:0]          r_win;
    logic [IDX_W-1:0]                r_idx;
    logic [NUM_EL-1:0][CNT_W-1:0]    w_cnt;
    logic                            w_clr, w_en, w_beat, w_last;

    assign w_clr  = (r_state == IDLE) && start;
    assign w_en   = (r_state == ACCUM);
    assign w_last = (r_state == DRAIN) && (r_idx == IDX_LAST);
    assign w_beat = (r_state == DRAIN) && out_ready;

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = ACCUM;
            ACCUM:   if (r_win == WIN_LAST) w_next = DRAIN;
            DRAIN:   if (out_ready && w_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Window counter wraps to zero on the last sample, ready for the next window.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST)
            r_win <= '0;
        else if (w_clr)
            r_win <= '0;
        else if (w_en)
            r_win <= r_win + WINDOW_LOG2'(1);
    end

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST)
            r_idx <= '0;
        else if (w_beat)
            r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        for (genvar h = 0; h < HEIGHT; h++) begin : g_row
            for (genvar w = 0; w < WIDTH; w++) begin : g_col
                stoch_signed_counter #(.CNT_W(CNT_W)) u_cnt (
                    .CLK  (CLK),
                    .nRST (nRST),
                    .clr  (w_clr),
                    .en   (w_en),
                    .p    (x_p[h][w][c]),
                    .m    (x_m[h][w][c]),
                    .cnt  (w_cnt[(h*WIDTH + w)*CHANNELS + c])
                );
            end
        end
    end

    // Outside DRAIN the index is zero and counters read zero after reset.
    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == DRAIN);
    assign out_idx   = r_idx;
    assign out_last  = w_last;
    assign out_data  = w_cnt[r_idx];

endmodule

// File: tb/tb_stoch_signed_fmap_decoder.sv
// Bench for the decoder at 2x2x1, N=8: table windows, random windows, reset abort.
module tb_stoch_signed_fmap_decoder;

    localparam int H = 2, W = 2, C = 1, WL2 = 3;
    localparam int N = 8, NEL = 4, CW = 5, IW = 2;

    logic                     CLK = 1'b0;
    logic                     nRST = 1'b1;
    logic                     start = 1'b0;
    logic [H-1:0][W-1:0][C-1:0] x_p = '0, x_m = '0;
    logic                     busy, out_valid, out_last;
    logic                     out_ready = 1'b0;
    logic signed [CW-1:0]     out_data;
    logic [IW-1:0]            out_idx;

    int n_tests = 0;
    int n_fail  = 0;

    stoch_signed_fmap_decoder #(
        .HEIGHT(H), .WIDTH(W), .CHANNELS(C), .WINDOW_LOG2(WL2)
    ) dut (
        .CLK(CLK), .nRST(nRST), .start(start), .x_p(x_p), .x_m(x_m),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [NEL-1:0][N-1:0] p;      // p[e][j]: element e, sample j
        logic [NEL-1:0][N-1:0] m;
        int                    e0, e1, e2, e3;
        int                    stall_beat;
        int                    stall_len;
        bit                    poke;   // pulse start during ACCUM and DRAIN
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: count = #(p-only samples) - #(m-only samples).
    function automatic int ref_count(input logic [N-1:0] p, input logic [N-1:0] m);
        int s = 0;
        for (int j = 0; j < N; j++) begin
            if (p[j] && !m[j]) s++;
            else if (m[j] && !p[j]) s--;
        end
        return s;
    endfunction

    task automatic drive_sample(input vec_t v, input int j);
        logic [NEL-1:0] bp, bm;
        for (int e = 0; e < NEL; e++) begin
            bp[e] = v.p[e][j];
            bm[e] = v.m[e][j];
        end
        x_p = bp;
        x_m = bm;
    endtask

    task automatic run_window(input vec_t v, input string tag);
        int exp[NEL];
        int nbeats, cyc, stalled;
        exp[0] = v.e0; exp[1] = v.e1; exp[2] = v.e2; exp[3] = v.e3;
        @(posedge CLK); #1 start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        chk({tag, " busy_after_start"}, int'(busy), 1);
        drive_sample(v, 0);
        for (int j = 1; j < N; j++) begin
            @(posedge CLK); #1 drive_sample(v, j);
            if (v.poke && j == 3) start = 1'b1;
            else start = 1'b0;
            if (j == N-1) chk({tag, " valid_before_end"}, int'(out_valid), 0);
        end
        @(posedge CLK); #1 start = 1'b0;
        chk({tag, " valid_at_drain"}, int'(out_valid), 1);
        nbeats = 0; cyc = 0; stalled = 0;
        while (nbeats < NEL && cyc < 100) begin
            x_p = 4'($urandom);
            x_m = 4'($urandom);
            start = (v.poke && cyc == 1);
            if (nbeats == v.stall_beat && stalled < v.stall_len) begin
                out_ready = 1'b0;
                stalled++;
            end else begin
                out_ready = 1'b1;
            end
            #1;
            chk({tag, " valid"}, int'(out_valid), 1);
            chk({tag, " idx"}, int'(out_idx), nbeats);
            chk({tag, " data"}, int'(out_data), exp[nbeats]);
            chk({tag, " last"}, int'(out_last), (nbeats == NEL-1) ? 1 : 0);
            if (out_ready) nbeats++;
            @(posedge CLK); #1;
            cyc++;
        end
        out_ready = 1'b0;
        start = 1'b0;
        chk({tag, " beats"}, nbeats, NEL);
        chk({tag, " idle_busy"}, int'(busy), 0);
        chk({tag, " idle_valid"}, int'(out_valid), 0);
    endtask

    function automatic vec_t mk(input logic [N-1:0] p0, p1, p2, p3,
                                input logic [N-1:0] m0, m1, m2, m3,
                                input int sb, sl, input bit pk);
        vec_t v;
        v.p[0] = p0; v.p[1] = p1; v.p[2] = p2; v.p[3] = p3;
        v.m[0] = m0; v.m[1] = m1; v.m[2] = m2; v.m[3] = m3;
        v.e0 = ref_count(p0, m0); v.e1 = ref_count(p1, m1);
        v.e2 = ref_count(p2, m2); v.e3 = ref_count(p3, m3);
        v.stall_beat = sb; v.stall_len = sl; v.poke = pk;
        return v;
    endfunction

    initial begin
        vec_t rv;
        // Hand-derived expected counts for the directed windows.
        tbl[0] = mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 9, 0, 1'b0);
        tbl[0].e0 = 8; tbl[0].e1 = 8; tbl[0].e2 = 8; tbl[0].e3 = 8;
        tbl[1] = mk(8'hFF, 8'h00, 8'hFF, 8'h55, 8'h00, 8'hFF, 8'hFF, 8'h00, 9, 0, 1'b0);
        tbl[1].e0 = 8; tbl[1].e1 = -8; tbl[1].e2 = 0; tbl[1].e3 = 4;
        tbl[2] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1, 3, 1'b0);
        tbl[2].e0 = -8; tbl[2].e1 = -8; tbl[2].e2 = -8; tbl[2].e3 = -8;
        tbl[3] = mk(8'h0F, 8'h01, 8'h00, 8'hFF, 8'h03, 8'hFE, 8'h00, 8'h80, 9, 0, 1'b1);
        tbl[3].e0 = 2; tbl[3].e1 = -6; tbl[3].e2 = 0; tbl[3].e3 = 7;
        tbl[4] = mk(8'hFF, 8'h00, 8'hAA, 8'h0F, 8'h00, 8'hFF, 8'h55, 8'h0F, 0, 6, 1'b0);
        tbl[4].e0 = 8; tbl[4].e1 = -8; tbl[4].e2 = 0; tbl[4].e3 = 0;

        repeat (2) @(posedge CLK);
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset valid", int'(out_valid), 0);
        chk("reset data", int'(out_data), 0);
        chk("reset idx", int'(out_idx), 0);
        chk("reset last", int'(out_last), 0);
        nRST = 1'b0;
        @(posedge CLK); #1;
        chk("idle hold busy", int'(busy), 0);

        for (int t = 0; t < 5; t++) run_window(tbl[t], $sformatf("tbl%0d", t));

        // Reset asserted mid-window discards the partial accumulation.
        @(posedge CLK); #1 start = 1'b1; x_p = '1; x_m = '0;
        @(posedge CLK); #1 start = 1'b0;
        repeat (4) @(posedge CLK);
        #1 nRST = 1'b1;
        #1;
        chk("async rst busy", int'(busy), 0);
        chk("async rst valid", int'(out_valid), 0);
        chk("async rst data", int'(out_data), 0);
        chk("async rst idx", int'(out_idx), 0);
        chk("async rst last", int'(out_last), 0);
        @(posedge CLK); #1 nRST = 1'b0;
        run_window(tbl[0], "post_rst");

        for (int r = 0; r < 8; r++) begin
            rv = mk(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'($urandom));
            run_window(rv, $sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
